// File: rtl/mips_mem_pkg.sv
// Shared definitions for the unified memory port: word geometry, requester
// source codes and the address legality check.
package mips_mem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic        SRC_IF     = 1'b0;
  localparam logic        SRC_DM     = 1'b1;

  // Word-aligned and the whole word fits inside the memory.
  function automatic logic addr_legal(input logic [63:0] addr, input int unsigned mem_bytes);
    logic [63:0] last_word;
    last_word = 64'(mem_bytes) - 64'(WORD_BYTES);
    return (addr[1:0] == 2'b00) && (addr <= last_word);
  endfunction

endpackage

// File: rtl/mem_starve_counter.sv
// Counts consecutive cycles in which a fetch request loses arbitration and
// flags when fetch must be given priority over data.
module mem_starve_counter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic if_grant,
  output logic win_override
);

  localparam logic [3:0] MAX_C = 4'(STARVE_MAX);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!if_req || if_grant) begin
      cnt_d = 4'd0;
    end else if (cnt_q < MAX_C) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign win_override = (cnt_q >= MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data
// load/store, rejecting illegal addresses and registering read data back.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_BYTES  = 1024,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_stall,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              err,
  output logic              err_src,
  output logic              Mem_Read,
  output logic              Mem_Write,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] Write_data,
  input  logic [DATA_W-1:0] Mem_Data
);

  logic dm_req, if_grant, dm_grant, if_legal, dm_legal, win_override;

  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              dm_valid_q, dm_valid_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              err_q, err_d;
  logic              err_src_q, err_src_d;

  mem_starve_counter #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk          (clk),
    .reset        (reset),
    .if_req       (if_req),
    .if_grant     (if_grant),
    .win_override (win_override)
  );

  // A request is granted even when illegal; it is then serviced as an error.
  always_comb begin
    dm_req   = dm_rd | dm_wr;
    if_legal = addr_legal(64'(if_addr), MEM_BYTES);
    dm_legal = addr_legal(64'(dm_addr), MEM_BYTES);
    if_grant = if_req & (~dm_req | win_override);
    dm_grant = dm_req & ~if_grant;
    if_stall = if_req & ~if_grant;
    dm_stall = dm_req & ~dm_grant;
  end

  // rd+wr together is a store, so Mem_Read and Mem_Write stay exclusive.
  always_comb begin
    Mem_Read   = 1'b0;
    Mem_Write  = 1'b0;
    Address    = '0;
    Write_data = '0;
    if (if_grant) begin
      Address  = if_addr;
      Mem_Read = if_legal & ~reset;
    end else if (dm_grant) begin
      Address = dm_addr;
      if (dm_wr) begin
        Write_data = dm_wdata;
        Mem_Write  = dm_legal & ~reset;
      end else begin
        Mem_Read = dm_legal & ~reset;
      end
    end else begin
      Address = '0;
    end
  end

  always_comb begin
    if_valid_d = if_grant & if_legal;
    if_rdata_d = if_valid_d ? Mem_Data : if_rdata_q;
    dm_valid_d = dm_grant & ~dm_wr & dm_legal;
    dm_rdata_d = dm_valid_d ? Mem_Data : dm_rdata_q;
    err_d      = (if_grant & ~if_legal) | (dm_grant & ~dm_legal);
    err_src_d  = (dm_grant & ~dm_legal) ? SRC_DM : SRC_IF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_valid_q <= 1'b0;
      if_rdata_q <= '0;
      dm_valid_q <= 1'b0;
      dm_rdata_q <= '0;
      err_q      <= 1'b0;
      err_src_q  <= 1'b0;
    end else begin
      if_valid_q <= if_valid_d;
      if_rdata_q <= if_rdata_d;
      dm_valid_q <= dm_valid_d;
      dm_rdata_q <= dm_rdata_d;
      err_q      <= err_d;
      err_src_q  <= err_src_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_rdata = if_rdata_q;
  assign dm_valid = dm_valid_q;
  assign dm_rdata = dm_rdata_q;
  assign err      = err_q;
  assign err_src  = err_src_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a big-endian byte memory model
// behind the port (combinational read, write at the clock edge).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset, init_mem;
  logic        if_req, dm_rd, dm_wr;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_stall, if_valid, dm_stall, dm_valid, err, err_src;
  logic [31:0] if_rdata, dm_rdata;
  logic        Mem_Read, Mem_Write;
  logic [31:0] Address, Write_data, Mem_Data;

  logic [7:0]  mem [0:1023];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_stall(dm_stall), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .err(err), .err_src(err_src),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Address(Address),
    .Write_data(Write_data), .Mem_Data(Mem_Data)
  );

  assign Mem_Data = {mem[Address[9:0]], mem[Address[9:0] + 10'd1],
                     mem[Address[9:0] + 10'd2], mem[Address[9:0] + 10'd3]};

  // Memory model: one-time image load, then stores commit at the edge.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 1024; k++) mem[k] <= 8'h00;
      {mem[0],  mem[1],  mem[2],  mem[3]}  <= 32'h8C090030;
      {mem[4],  mem[5],  mem[6],  mem[7]}  <= 32'h20080005;
      {mem[48], mem[49], mem[50], mem[51]} <= 32'h00000004;
      {mem[60], mem[61], mem[62], mem[63]} <= 32'h11223344;
    end else if (Mem_Write) begin
      {mem[Address[9:0]], mem[Address[9:0] + 10'd1],
       mem[Address[9:0] + 10'd2], mem[Address[9:0] + 10'd3]} <= Write_data;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drop_all();
    if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
    if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
  endtask

  logic [31:0] bad_addr [2];

  initial begin
    bad_addr[0] = 32'h00000031;
    bad_addr[1] = 32'h00000400;
    reset = 1'b1; init_mem = 1'b1;
    drop_all();
    @(posedge clk); #1 init_mem = 1'b0;

    // Strobes must stay low while reset is high, even with a request.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0;
    #1 check_eq("rst_strobes", {30'h0, Mem_Read, Mem_Write}, 32'h0);
    @(negedge clk);
    reset = 1'b0; drop_all();

    // 1: idle after reset
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check_eq("idle_flags", {24'h0, Mem_Read, Mem_Write, if_valid, dm_valid,
                              err, err_src, if_stall, dm_stall}, 32'h0);
      check_eq("idle_addr", Address | Write_data | if_rdata | dm_rdata, 32'h0);
    end

    // 2: lone fetch
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0;
    #1;
    check_eq("f_mem_read", {31'h0, Mem_Read}, 32'h1);
    check_eq("f_address", Address, 32'h0);
    check_eq("f_stall", {31'h0, if_stall}, 32'h0);
    @(negedge clk);
    drop_all();
    check_eq("f_valid", {31'h0, if_valid}, 32'h1);
    check_eq("f_rdata", if_rdata, 32'h8C090030);

    // 3: contention, data wins three times then fetch is forced through
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0 && i < 4) begin
        check_eq("c_dm_valid", {31'h0, dm_valid}, 32'h1);
        check_eq("c_dm_rdata", dm_rdata, 32'h00000004);
        check_eq("c_if_valid", {31'h0, if_valid}, 32'h0);
      end else if (i == 4) begin
        check_eq("c_if_valid4", {31'h0, if_valid}, 32'h1);
        check_eq("c_if_rdata4", if_rdata, 32'h20080005);
        check_eq("c_dm_valid4", {31'h0, dm_valid}, 32'h0);
      end
      if (i < 4) begin
        if_req = 1'b1; if_addr = 32'h4; dm_rd = 1'b1; dm_addr = 32'h30;
        #1;
        if (i < 3) begin
          check_eq("c_addr_dm", Address, 32'h30);
          check_eq("c_stalls_dm", {30'h0, if_stall, dm_stall}, 32'h2);
        end else begin
          check_eq("c_addr_if", Address, 32'h4);
          check_eq("c_stalls_if", {30'h0, if_stall, dm_stall}, 32'h1);
        end
      end else begin
        drop_all();
      end
    end

    // 4: store then load of the same word; rd+wr together acts as store
    @(negedge clk);
    dm_wr = 1'b1; dm_addr = 32'h38; dm_wdata = 32'hDEADBEEF;
    #1;
    check_eq("st_strobes", {30'h0, Mem_Read, Mem_Write}, 32'h1);
    check_eq("st_wdata", Write_data, 32'hDEADBEEF);
    check_eq("st_addr", Address, 32'h38);
    @(negedge clk);
    check_eq("st_no_valid", {31'h0, dm_valid}, 32'h0);
    dm_wr = 1'b0; dm_rd = 1'b1; dm_wdata = 32'h0;
    #1 check_eq("ld_strobes", {30'h0, Mem_Read, Mem_Write}, 32'h2);
    @(negedge clk);
    check_eq("ld_valid", {31'h0, dm_valid}, 32'h1);
    check_eq("ld_rdata", dm_rdata, 32'hDEADBEEF);
    dm_wr = 1'b1; dm_rd = 1'b1; dm_wdata = 32'hCAFEF00D;
    #1 check_eq("rw_strobes", {30'h0, Mem_Read, Mem_Write}, 32'h1);
    @(negedge clk);
    check_eq("rw_no_valid", {31'h0, dm_valid}, 32'h0);
    dm_wr = 1'b0;
    @(negedge clk);
    check_eq("rw_rdata", dm_rdata, 32'hCAFEF00D);
    drop_all();

    // 5: illegal data addresses, then an illegal fetch
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      dm_rd = 1'b1; dm_addr = bad_addr[j];
      #1;
      check_eq("bad_dm_strobes", {30'h0, Mem_Read, Mem_Write}, 32'h0);
      check_eq("bad_dm_stall", {31'h0, dm_stall}, 32'h0);
      @(negedge clk);
      drop_all();
      check_eq("bad_dm_err", {29'h0, err, err_src, dm_valid}, 32'h6);
    end
    if_req = 1'b1; if_addr = 32'h2;
    #1 check_eq("bad_if_strobes", {30'h0, Mem_Read, Mem_Write}, 32'h0);
    @(negedge clk);
    drop_all();
    check_eq("bad_if_err", {29'h0, err, err_src, if_valid}, 32'h4);
    @(negedge clk);
    check_eq("err_pulse", {31'h0, err}, 32'h0);

    // 6: reset during a store suppresses it and clears pending valid
    dm_rd = 1'b1; dm_addr = 32'h30;
    @(negedge clk);
    check_eq("rs_pending", {31'h0, dm_valid}, 32'h1);
    reset = 1'b1; dm_rd = 1'b0; dm_wr = 1'b1; dm_addr = 32'h3C; dm_wdata = 32'hBAD0BAD0;
    #1 check_eq("rs_no_write", {31'h0, Mem_Write}, 32'h0);
    @(negedge clk);
    check_eq("rs_cleared", {30'h0, dm_valid, err}, 32'h0);
    check_eq("rs_mem", {mem[60], mem[61], mem[62], mem[63]}, 32'h11223344);
    reset = 1'b0; drop_all();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
